// File: rtl/fifo_gen_pkg.sv
// Shared mode constants and width helpers for the generic stream FIFO family.
package fifo_gen_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_gen_fwft_if.sv
// Producer/consumer handshake bundle for fifo_gen_fwft.
interface fifo_gen_fwft_if
  import fifo_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] din;
  logic             write;
  logic             full_n;
  logic [WIDTH-1:0] dout;
  logic             read;
  logic             empty_n;
  logic [CNT_W-1:0] count;
  logic             almost_full_n;
  logic             almost_empty_n;
  logic             ovf;
  logic             udf;

  modport master (
    output din, write, read,
    input  full_n, dout, empty_n, count, almost_full_n, almost_empty_n, ovf, udf
  );

  modport slave (
    input  din, write, read,
    output full_n, dout, empty_n, count, almost_full_n, almost_empty_n, ovf, udf
  );
endinterface

// File: rtl/fifo_gen_fwft_ram.sv
// Simple dual-port storage: synchronous write, registered read with enable, no reset.
module fifo_ram_2p #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_gen_fwft.sv
// Single-clock FIFO with standard/FWFT read modes, occupancy count and registered status flags.
module fifo_gen_fwft
  import fifo_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FWFT     = FIFO_STD,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input logic            clk,
  input logic            ap_rst_n,
  fifo_gen_fwft_if.slave bus
);
  localparam int unsigned ADDR_W = addr_w(DEPTH);
  localparam int unsigned CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

  logic [CNT_W-1:0] wr_ptr, rd_ptr, count_r, count_nxt;
  logic             full_n_r, empty_n_r, af_n_r, ae_n_r, ovf_r, udf_r, q_seen;
  logic             wr_acc, rd_acc, ram_re, empty_n_nxt;
  logic [WIDTH-1:0] ram_q;

  assign wr_acc = bus.write && full_n_r;
  assign rd_acc = bus.read && empty_n_r;

  // In FWFT mode the RAM read register is the output stage: rd_ptr tracks
  // prefetches, and a fetch happens whenever the stage is empty or being popped.
  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      logic mem_has;
      assign mem_has     = (wr_ptr != rd_ptr);
      assign ram_re      = mem_has && (!empty_n_r || rd_acc);
      assign empty_n_nxt = ram_re || (empty_n_r && !rd_acc);
    end else begin : g_std
      assign ram_re      = rd_acc;
      assign empty_n_nxt = (count_nxt != '0);
    end
  endgenerate

  always_comb begin
    count_nxt = count_r;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_r + CNT_W'(1);
      2'b01:   count_nxt = count_r - CNT_W'(1);
      default: count_nxt = count_r;
    endcase
  end

  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_r   <= '0;
      full_n_r  <= 1'b0;
      empty_n_r <= 1'b0;
      af_n_r    <= 1'b1;
      ae_n_r    <= 1'b0;
      ovf_r     <= 1'b0;
      udf_r     <= 1'b0;
      q_seen    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CNT_W'(1);
      if (ram_re) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
        q_seen <= 1'b1;
      end
      count_r   <= count_nxt;
      full_n_r  <= (count_nxt != FULL_C);
      empty_n_r <= empty_n_nxt;
      af_n_r    <= !(count_nxt >= AF_C);
      ae_n_r    <= !(count_nxt <= AE_C);
      ovf_r     <= bus.write && !full_n_r;
      udf_r     <= bus.read && !empty_n_r;
    end
  end

  fifo_ram_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(bus.din),
    .re   (ram_re),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(ram_q)
  );

  // The RAM register has no reset, so dout reads zero until the first post-reset fetch.
  assign bus.dout           = q_seen ? ram_q : '0;
  assign bus.count          = count_r;
  assign bus.full_n         = full_n_r;
  assign bus.empty_n        = empty_n_r;
  assign bus.almost_full_n  = af_n_r;
  assign bus.almost_empty_n = ae_n_r;
  assign bus.ovf            = ovf_r;
  assign bus.udf            = udf_r;
endmodule

// File: tb/tb_fifo_gen_fwft.sv
// Directed bench for fifo_gen_fwft: one standard-mode and one FWFT-mode instance, DEPTH=8.
module tb_fifo_gen_fwft;
  import fifo_gen_pkg::*;

  logic clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  fifo_gen_fwft_if #(.WIDTH(16), .DEPTH(8)) s_if ();
  fifo_gen_fwft_if #(.WIDTH(16), .DEPTH(8)) f_if ();

  fifo_gen_fwft #(
    .WIDTH(16), .DEPTH(8), .FWFT(FIFO_STD), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_std (
    .clk     (clk),
    .ap_rst_n(ap_rst_n),
    .bus     (s_if.slave)
  );

  fifo_gen_fwft #(
    .WIDTH(16), .DEPTH(8), .FWFT(FIFO_FWFT), .AF_LEVEL(6), .AE_LEVEL(2)
  ) u_fw (
    .clk     (clk),
    .ap_rst_n(ap_rst_n),
    .bus     (f_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "s_count"}, s_if.count, 0);
    chk({pfx, "s_dout"}, s_if.dout, 0);
    chk({pfx, "s_full_n"}, s_if.full_n, 0);
    chk({pfx, "s_empty_n"}, s_if.empty_n, 0);
    chk({pfx, "s_af_n"}, s_if.almost_full_n, 1);
    chk({pfx, "s_ae_n"}, s_if.almost_empty_n, 0);
    chk({pfx, "s_ovf"}, s_if.ovf, 0);
    chk({pfx, "s_udf"}, s_if.udf, 0);
    chk({pfx, "f_count"}, f_if.count, 0);
    chk({pfx, "f_dout"}, f_if.dout, 0);
    chk({pfx, "f_empty_n"}, f_if.empty_n, 0);
  endtask

  task automatic chk_std_flags(input string pfx, input int unsigned mc);
    chk({pfx, "_count"}, s_if.count, mc);
    chk({pfx, "_full_n"}, s_if.full_n, (mc != 8) ? 1 : 0);
    chk({pfx, "_empty_n"}, s_if.empty_n, (mc != 0) ? 1 : 0);
    chk({pfx, "_af_n"}, s_if.almost_full_n, (mc >= 6) ? 0 : 1);
    chk({pfx, "_ae_n"}, s_if.almost_empty_n, (mc <= 2) ? 0 : 1);
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] d;
    logic [15:0] e;
    logic wr, rd;
    int unsigned mc;

    s_if.din = '0; s_if.write = 1'b0; s_if.read = 1'b0;
    f_if.din = '0; f_if.write = 1'b0; f_if.read = 1'b0;

    // Power-on reset, release mid-cycle
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst_");
    ap_rst_n = 1'b1;
    step();
    chk("rel_s_full_n", s_if.full_n, 1);
    chk("rel_f_full_n", f_if.full_n, 1);

    // Standard mode: underflow, then single word round trip
    s_if.read = 1'b1;
    step();
    chk("s_udf_pulse", s_if.udf, 1);
    chk("s_udf_dout", s_if.dout, 16'h0000);
    s_if.read = 1'b0;
    step();
    chk("s_udf_clear", s_if.udf, 0);
    s_if.write = 1'b1; s_if.din = 16'h00A5;
    step();
    chk("s_a5_empty_n", s_if.empty_n, 1);
    chk("s_a5_count", s_if.count, 1);
    s_if.write = 1'b0; s_if.read = 1'b1;
    step();
    chk("s_a5_dout", s_if.dout, 16'h00A5);
    chk("s_a5_empty_after", s_if.empty_n, 0);
    chk("s_a5_count_after", s_if.count, 0);
    s_if.read = 1'b0;

    // Fill to full, overflow, simultaneous read+write when full, drain
    for (int i = 1; i <= 8; i++) begin
      s_if.write = 1'b1; s_if.din = 16'(i);
      step();
      chk_std_flags($sformatf("fill%0d", i), i);
    end
    s_if.din = 16'hDEAD;
    step();
    chk("s_ovf_pulse", s_if.ovf, 1);
    chk("s_ovf_count", s_if.count, 8);
    s_if.din = 16'hBEEF; s_if.read = 1'b1;
    step();
    chk("s_fullrw_ovf", s_if.ovf, 1);
    chk("s_fullrw_count", s_if.count, 7);
    chk("s_fullrw_full_n", s_if.full_n, 1);
    chk("s_fullrw_dout", s_if.dout, 16'h0001);
    s_if.write = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      step();
      chk($sformatf("s_drain_dout%0d", k), s_if.dout, 16'(k));
      if (k == 2) chk("s_drain_ovf_clear", s_if.ovf, 0);
    end
    s_if.read = 1'b0;
    chk_std_flags("s_drained", 0);

    // Pointer wrap: random traffic with occupancy held in 1..7
    d = 16'($urandom);
    s_if.write = 1'b1; s_if.din = d;
    step();
    q.push_back(d);
    for (int c = 0; c < 50; c++) begin
      mc = q.size();
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (mc == 7 && wr && !rd) wr = 1'b0;
      if (mc == 1 && rd && !wr) rd = 1'b0;
      d = 16'($urandom);
      s_if.write = wr; s_if.read = rd; s_if.din = d;
      step();
      if (rd) begin
        e = q.pop_front();
        chk($sformatf("wrap_dout%0d", c), s_if.dout, e);
      end
      if (wr) q.push_back(d);
      chk_std_flags($sformatf("wrap%0d", c), q.size());
    end
    s_if.write = 1'b0; s_if.read = 1'b1;
    mc = q.size();
    for (int c = 0; c < int'(mc); c++) begin
      step();
      e = q.pop_front();
      chk($sformatf("wrap_drain%0d", c), s_if.dout, e);
    end
    s_if.read = 1'b0;
    chk_std_flags("wrap_end", 0);

    // FWFT: underflow, fall-through latency
    f_if.read = 1'b1;
    step();
    chk("f_udf_pulse", f_if.udf, 1);
    chk("f_udf_dout", f_if.dout, 0);
    f_if.read = 1'b0;
    f_if.write = 1'b1; f_if.din = 16'h1234;
    step();
    chk("f_k_empty_n", f_if.empty_n, 0);
    chk("f_k_count", f_if.count, 1);
    f_if.write = 1'b0;
    step();
    chk("f_k1_empty_n", f_if.empty_n, 1);
    chk("f_k1_dout", f_if.dout, 16'h1234);
    f_if.read = 1'b1;
    step();
    chk("f_pop_empty_n", f_if.empty_n, 0);
    chk("f_pop_count", f_if.count, 0);

    // FWFT: preload two words, then continuous write+read stream
    f_if.read = 1'b0; f_if.write = 1'b1; f_if.din = 16'h0100;
    step();
    f_if.din = 16'h0101;
    step();
    chk("f_pre_count", f_if.count, 2);
    chk("f_pre_empty_n", f_if.empty_n, 1);
    chk("f_pre_dout", f_if.dout, 16'h0100);
    f_if.read = 1'b1;
    for (int i = 2; i <= 255; i++) begin
      f_if.din = 16'(32'h100 + i);
      step();
      chk($sformatf("f_str_dout%0d", i), f_if.dout, 32'h100 + i - 1);
      chk($sformatf("f_str_count%0d", i), f_if.count, 2);
      chk($sformatf("f_str_empty_n%0d", i), f_if.empty_n, 1);
    end
    f_if.write = 1'b0;
    step();
    chk("f_tail_dout", f_if.dout, 16'h01FF);
    chk("f_tail_count", f_if.count, 1);
    step();
    chk("f_tail_empty_n", f_if.empty_n, 0);
    chk("f_tail_count0", f_if.count, 0);
    f_if.read = 1'b0;

    // Asynchronous reset mid-stream with five words held
    for (int i = 0; i < 5; i++) begin
      s_if.write = 1'b1; s_if.din = 16'h5500 + 16'(i);
      step();
    end
    s_if.write = 1'b0;
    chk("pre_rst_count", s_if.count, 5);
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk_reset_state("arst_");
    repeat (2) @(posedge clk);
    #1;
    ap_rst_n = 1'b1;
    step();
    chk("arst_rel_full_n", s_if.full_n, 1);
    s_if.write = 1'b1; s_if.din = 16'h7777;
    step();
    s_if.write = 1'b0; s_if.read = 1'b1;
    step();
    chk("arst_dout", s_if.dout, 16'h7777);
    chk("arst_empty_n", s_if.empty_n, 0);
    s_if.read = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
